counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_if.sv | 44 ++++
 rtl/counter_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_counter_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if
//   Groups the handshake, register-bus, measurement and result-stream
//   signals of counter_ctrl into one bundle.
//   master : the controller side (counter_ctrl itself)
//   slave  : the environment side (command source, counter block, sink)
// Signals:
//   cmd_valid/cmd_ready/cmd_time/cmd_mask : run request handshake
//   bus_addr/bus_wdata/bus_we/bus_rdata   : counter block register bus
//   start/stop                            : measurement start pulse / done level
//   m_data/m_valid/m_ready/m_last         : result byte stream
//   busy/timeout_err                      : status
interface counter_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_CHN      = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [7:0]            cmd_time;
  logic [N_CHN-1:0]      cmd_mask;
  logic [7:0]            bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_we;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  start;
  logic                  stop;
  logic [7:0]            m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic                  busy;
  logic                  timeout_err;

  modport master (
    input  cmd_valid, cmd_time, cmd_mask, bus_rdata, stop, m_ready,
    output cmd_ready, bus_addr, bus_wdata, bus_we, start,
    output m_data, m_valid, m_last, busy, timeout_err
  );

  modport slave (
    output cmd_valid, cmd_time, cmd_mask, bus_rdata, stop, m_ready,
    input  cmd_ready, bus_addr, bus_wdata, bus_we, start,
    input  m_data, m_valid, m_last, busy, timeout_err
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Runs one measurement on a counter block: programs gate time and channel
//   mask over a simple register bus, pulses start, waits for the stop level
//   (with a cycle timeout), then reads back 4 bytes per channel and streams
//   them out over a valid/ready byte interface.
// Ports:
//   clk   : single clock, all logic on its rising edge
//   res_n : asynchronous active-low reset
//   io    : counter_ctrl_if.master (command, bus, start/stop, stream, status)
// All outputs are registered; they are decoded from the next-state values.
module counter_ctrl #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          N_CHN       = 32,
  parameter logic [7:0]  START_ADDR  = 8'h26,
  parameter logic [31:0] TIMEOUT_CYC = 32'd4_000_000_000
) (
  input  logic           clk,
  input  logic           res_n,
  counter_ctrl_if.master io
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR        = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_STOP = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;
  localparam logic [2:0] S_RD        = 3'd5;
  localparam logic [2:0] S_STREAM    = 3'd6;

  localparam int            NBYTES   = 4 * N_CHN;
  localparam int            IW       = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  logic [2:0]            state_q, state_d;
  logic [1:0]            phase_q, phase_d;     // cycle within a write / read / post-stop wait
  logic [2:0]            widx_q, widx_d;       // which of the 5 configuration writes
  logic [IW-1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]           wait_cnt_q, wait_cnt_d;
  logic [7:0]            time_q, time_d;
  logic [31:0]           mask_q, mask_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic [7:0]            bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic                  bus_we_q, bus_we_d;
  logic                  start_q, start_d;
  logic [7:0]            m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;

  // Configuration byte for write number idx: gate time, then mask bytes LSB first.
  function automatic logic [7:0] wr_byte(input logic [2:0] idx, input logic [7:0] t,
                                         input logic [31:0] m);
    case (idx)
      3'd0:    wr_byte = t;
      3'd1:    wr_byte = m[7:0];
      3'd2:    wr_byte = m[15:8];
      3'd3:    wr_byte = m[23:16];
      3'd4:    wr_byte = m[31:24];
      default: wr_byte = 8'd0;
    endcase
  endfunction

  // Next-state logic and registered-output decode.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    widx_d        = widx_q;
    byte_idx_d    = byte_idx_q;
    wait_cnt_d    = wait_cnt_q;
    time_d        = time_q;
    mask_d        = mask_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (io.cmd_valid && cmd_ready_q) begin
          time_d        = io.cmd_time;
          mask_d        = 32'(io.cmd_mask);
          timeout_err_d = 1'b0;
          state_d       = S_WR;
          phase_d       = 2'd0;
          widx_d        = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        // phase 0: strobe, 1: hold, 2: gap
        if (phase_q == 2'd2) begin
          phase_d = 2'd0;
          if (widx_q == 3'd4) begin
            state_d = S_START;
          end else begin
            widx_d = widx_q + 3'd1;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      S_START: begin
        state_d    = S_WAIT_STOP;
        wait_cnt_d = 32'd0;
      end
      S_WAIT_STOP: begin
        if (io.stop) begin
          state_d = S_WAIT_IDLE;
          phase_d = 2'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
          if (wait_cnt_q + 32'd1 == TIMEOUT_CYC) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            state_d = S_WAIT_STOP;
          end
        end
      end
      S_WAIT_IDLE: begin
        // phase 0 waits for stop low; phases 1 and 2 are the settle cycles
        if (phase_q == 2'd0) begin
          if (!io.stop) begin
            phase_d = 2'd1;
          end else begin
            phase_d = 2'd0;
          end
        end else if (phase_q == 2'd1) begin
          phase_d = 2'd2;
        end else begin
          state_d    = S_RD;
          phase_d    = 2'd0;
          byte_idx_d = '0;
        end
      end
      S_RD: begin
        if (phase_q == 2'd2) begin
          state_d = S_STREAM;
          phase_d = 2'd0;
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      S_STREAM: begin
        if (io.m_ready) begin
          if (byte_idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = S_RD;
            phase_d    = 2'd0;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 2'd0;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    bus_we_d    = (state_d == S_WR) && (phase_d == 2'd0);
    start_d     = (state_d == S_START);
    m_valid_d   = (state_d == S_STREAM);
    m_last_d    = (state_d == S_STREAM) && (byte_idx_d == LAST_IDX);

    if (state_d == S_WR) begin
      bus_addr_d  = START_ADDR + 8'd1 + {5'd0, widx_d};
      bus_wdata_d = DATA_WIDTH'(wr_byte(widx_d, time_d, mask_d));
    end else if (state_d == S_RD) begin
      bus_addr_d  = START_ADDR + 8'd6 + 8'(byte_idx_d);
      bus_wdata_d = '0;
    end else begin
      bus_addr_d  = 8'd0;
      bus_wdata_d = '0;
    end

    // Capture on the last read-hold cycle, then hold while the sink stalls.
    if (state_d == S_STREAM) begin
      if (state_q == S_RD) begin
        m_data_d = io.bus_rdata[7:0];
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      m_data_d = 8'd0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= S_IDLE;
      phase_q       <= 2'd0;
      widx_q        <= 3'd0;
      byte_idx_q    <= '0;
      wait_cnt_q    <= 32'd0;
      time_q        <= 8'd0;
      mask_q        <= 32'd0;
      cmd_ready_q   <= 1'b1;
      bus_addr_q    <= 8'd0;
      bus_wdata_q   <= '0;
      bus_we_q      <= 1'b0;
      start_q       <= 1'b0;
      m_data_q      <= 8'd0;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      widx_q        <= widx_d;
      byte_idx_q    <= byte_idx_d;
      wait_cnt_q    <= wait_cnt_d;
      time_q        <= time_d;
      mask_q        <= mask_d;
      cmd_ready_q   <= cmd_ready_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_we_q      <= bus_we_d;
      start_q       <= start_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign io.cmd_ready   = cmd_ready_q;
  assign io.bus_addr    = bus_addr_q;
  assign io.bus_wdata   = bus_wdata_q;
  assign io.bus_we      = bus_we_q;
  assign io.start       = start_q;
  assign io.m_data      = m_data_q;
  assign io.m_valid     = m_valid_q;
  assign io.m_last      = m_last_q;
  assign io.busy        = busy_q;
  assign io.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl
//   Table-driven bench for counter_ctrl: each table row is one run request
//   with its hand-computed write bytes and run options; hand-written
//   sequences cover reset, mid-stream reset and the stop timeout.
//   The counter block model returns ram[k]=k with k = bus_addr - 0x26.
module tb_counter_ctrl;
  logic clk;
  logic res_n;

  counter_ctrl_if #(.DATA_WIDTH(8), .N_CHN(32)) io ();

  counter_ctrl #(
    .DATA_WIDTH (8),
    .N_CHN      (32),
    .START_ADDR (8'h26),
    .TIMEOUT_CYC(32'd100)
  ) dut (
    .clk  (clk),
    .res_n(res_n),
    .io   (io)
  );

  assign io.bus_rdata = io.bus_addr - 8'h26;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t;
    logic [31:0] m;
    logic [39:0] exp_w;    // expected write bytes, write 0 in [7:0]
    bit          hold;     // keep cmd_valid high after acceptance
    bit          rnd;      // random m_ready stalls
    bit          stop_wr;  // drive stop high during the writes
    int          abort_at; // return at this byte index (-1: run to the end)
  } vec_t;

  vec_t tbl[4];
  int   total;
  int   bad;
  int   we_dbl;
  logic prev_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // No two consecutive write strobes.
  always @(negedge clk) begin
    if (res_n && prev_we && io.bus_we) we_dbl <= we_dbl + 1;
    prev_we <= io.bus_we;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  io.bus_addr, 32'h0);
    chk({tag, "_wdata"}, io.bus_wdata, 32'h0);
    chk({tag, "_we"},    io.bus_we, 32'h0);
    chk({tag, "_start"}, io.start, 32'h0);
    chk({tag, "_mdata"}, io.m_data, 32'h0);
    chk({tag, "_mvalid"}, io.m_valid, 32'h0);
    chk({tag, "_mlast"}, io.m_last, 32'h0);
    chk({tag, "_busy"},  io.busy, 32'h0);
    chk({tag, "_terr"},  io.timeout_err, 32'h0);
    chk({tag, "_ready"}, io.cmd_ready, 32'h1);
  endtask

  // Called at a falling edge; issues one run and checks it end to end.
  task automatic run_cmd(input vec_t v);
    int         g;
    int         stall;
    logic [7:0] eb;
    g = 0;
    while (io.cmd_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready_idle", io.cmd_ready, 32'h1);
    io.cmd_valid = 1'b1;
    io.cmd_time  = v.t;
    io.cmd_mask  = v.m;
    if (v.stop_wr) io.stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        eb = v.exp_w[8*i +: 8];
        chk($sformatf("wr%0d_c%0d_we", i, c), io.bus_we, (c == 0) ? 32'h1 : 32'h0);
        if (c < 2) begin
          chk($sformatf("wr%0d_c%0d_addr", i, c), io.bus_addr, 32'h27 + i);
          chk($sformatf("wr%0d_c%0d_wdata", i, c), io.bus_wdata, {24'h0, eb});
        end
        chk($sformatf("wr%0d_c%0d_busy", i, c), io.busy, 32'h1);
        chk($sformatf("wr%0d_c%0d_cmd_ready", i, c), io.cmd_ready, 32'h0);
        chk($sformatf("wr%0d_c%0d_start", i, c), io.start, 32'h0);
        if (i == 0 && c == 0) begin
          chk("terr_cleared", io.timeout_err, 32'h0);
          if (!v.hold) io.cmd_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("start_pulse", io.start, 32'h1);
    @(negedge clk);
    chk("start_one_cycle", io.start, 32'h0);
    io.stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("wait_addr_zero", io.bus_addr, 32'h0);
      chk("wait_no_valid", io.m_valid, 32'h0);
    end
    io.stop = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j <= 2) begin
        chk($sformatf("settle%0d_addr", j), io.bus_addr, 32'h0);
        chk($sformatf("settle%0d_mvalid", j), io.m_valid, 32'h0);
      end else if (j <= 5) begin
        chk($sformatf("rd0_hold%0d_addr", j), io.bus_addr, 32'h2C);
        chk($sformatf("rd0_hold%0d_we", j), io.bus_we, 32'h0);
        chk($sformatf("rd0_hold%0d_mvalid", j), io.m_valid, 32'h0);
      end else begin
        chk("first_byte_latency", io.m_valid, 32'h1);
      end
    end
    for (int n = 0; n < 128; n++) begin
      g = 0;
      while (io.m_valid !== 1'b1 && g < 12) begin
        @(negedge clk);
        g++;
      end
      chk($sformatf("byte%0d_arrive", n), io.m_valid, 32'h1);
      if (io.m_valid !== 1'b1) return;
      chk($sformatf("byte%0d_data", n), io.m_data, 32'h6 + n);
      chk($sformatf("byte%0d_last", n), io.m_last, (n == 127) ? 32'h1 : 32'h0);
      chk($sformatf("byte%0d_cmd_ready", n), io.cmd_ready, 32'h0);
      if (n == v.abort_at) return;
      stall = v.rnd ? int'($urandom_range(0, 3)) : 0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk($sformatf("byte%0d_stall_valid", n), io.m_valid, 32'h1);
        chk($sformatf("byte%0d_stall_data", n), io.m_data, 32'h6 + n);
        chk($sformatf("byte%0d_stall_last", n), io.m_last, (n == 127) ? 32'h1 : 32'h0);
      end
      io.m_ready = 1'b1;
      @(negedge clk);
      io.m_ready = 1'b0;
      chk($sformatf("byte%0d_valid_drop", n), io.m_valid, 32'h0);
      if (n < 127) begin
        chk($sformatf("byte%0d_next_addr", n), io.bus_addr, 32'h2C + n + 1);
      end else begin
        chk("end_busy", io.busy, 32'h0);
        chk("end_cmd_ready", io.cmd_ready, 32'h1);
        chk("end_mlast", io.m_last, 32'h0);
      end
    end
  endtask

  initial begin
    vec_t v;
    int   g;
    total = 0;
    bad = 0;
    we_dbl = 0;
    prev_we = 1'b0;
    res_n = 1'b0;
    io.cmd_valid = 1'b0;
    io.cmd_time = 8'h00;
    io.cmd_mask = 32'h0;
    io.stop = 1'b0;
    io.m_ready = 1'b0;

    tbl[0] = '{t: 8'h03, m: 32'hA5A5_0F01, exp_w: 40'hA5_A5_0F_01_03,
               hold: 1'b0, rnd: 1'b0, stop_wr: 1'b0, abort_at: -1};
    tbl[1] = '{t: 8'hFF, m: 32'h1234_5678, exp_w: 40'h12_34_56_78_FF,
               hold: 1'b1, rnd: 1'b1, stop_wr: 1'b1, abort_at: -1};
    tbl[2] = '{t: 8'h00, m: 32'h0000_0000, exp_w: 40'h00_00_00_00_00,
               hold: 1'b1, rnd: 1'b1, stop_wr: 1'b0, abort_at: -1};
    tbl[3] = '{t: 8'h5A, m: 32'hFFFF_FFFF, exp_w: 40'hFF_FF_FF_FF_5A,
               hold: 1'b0, rnd: 1'b0, stop_wr: 1'b0, abort_at: 40};

    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    res_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      run_cmd(tbl[i]);
      if (tbl[i].abort_at >= 0) begin
        #2 res_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge clk);
        res_n = 1'b1;
        run_cmd(tbl[0]);
      end
    end

    // Stop never arrives: timeout at wait count 100.
    io.cmd_valid = 1'b1;
    io.cmd_time = 8'h01;
    io.cmd_mask = 32'h1;
    @(negedge clk);
    io.cmd_valid = 1'b0;
    g = 0;
    while (io.start !== 1'b1 && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("to_start_seen", io.start, 32'h1);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d_mvalid", k), io.m_valid, 32'h0);
    end
    chk("to_busy_before", io.busy, 32'h1);
    chk("to_terr_before", io.timeout_err, 32'h0);
    @(negedge clk);
    chk("to_terr_set", io.timeout_err, 32'h1);
    chk("to_idle_busy", io.busy, 32'h0);
    chk("to_idle_ready", io.cmd_ready, 32'h1);
    chk("to_no_mvalid", io.m_valid, 32'h0);
    repeat (3) @(negedge clk);
    chk("to_terr_sticky", io.timeout_err, 32'h1);
    v = tbl[1];
    v.hold = 1'b0;
    v.rnd = 1'b0;
    v.stop_wr = 1'b0;
    run_cmd(v);

    chk("we_no_back_to_back", we_dbl, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
